// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: width encodings, FSM state enum and the
// access check that the decoder's exception logic also uses.
package load_store_unit_pkg;

  localparam logic [1:0] WIDTH_BYTE    = 2'd0;
  localparam logic [1:0] WIDTH_HALF    = 2'd1;
  localparam logic [1:0] WIDTH_WORD    = 2'd2;
  localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    COMPLETE = 2'd2
  } lsu_state_e;

  // True when the access cannot be issued: misaligned, or illegal width.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: misaligned = 1'b0;
      WIDTH_HALF: misaligned = offset[0];
      WIDTH_WORD: misaligned = (offset != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  endfunction

  // Active byte lanes for an aligned access.
  function automatic logic [3:0] byte_enable(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: byte_enable = 4'b0001 << offset;
      WIDTH_HALF: byte_enable = 4'b0011 << offset;
      default:    byte_enable = 4'b1111;
    endcase
  endfunction

  // Store data replicated per width, then moved onto its lanes.
  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [1:0] offset,
                                            input logic [31:0] data);
    logic [31:0] rep;
    case (width)
      WIDTH_BYTE: rep = {4{data[7:0]}};
      WIDTH_HALF: rep = {2{data[15:0]}};
      default:    rep = data;
    endcase
    lane_data = rep << {offset, 3'b000};
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane select and sign/zero extension (combinational).
// Ports: read_word (bus word), offset (byte offset), width, sign_extend,
//        load_data_c (extended result).
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] read_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        sign_extend,
  output logic [31:0] load_data_c
);

  logic [31:0] shifted;

  assign shifted = read_word >> {offset, 3'b000};

  always_comb begin
    load_data_c = shifted;
    case (width)
      WIDTH_BYTE: load_data_c = {{24{sign_extend & shifted[7]}}, shifted[7:0]};
      WIDTH_HALF: load_data_c = {{16{sign_extend & shifted[15]}}, shifted[15:0]};
      default:    load_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per Start, word-aligned bus
// transaction with byte enables, load extraction/extension, wait timeout.
// Ports: Clock/Reset; request inputs Start, IsMemoryRead, IsMemoryWrite,
//        MemoryAccessWidth, MemoryAccessSignExtend, Address, StoreData;
//        status Busy, Done, Fault, LoadData; bus MemRequest, MemWriteEnable,
//        MemAddress, MemByteEnable, MemWriteData, MemReady, MemReadData.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WaitLimit = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        IsMemoryRead,
  input  logic        IsMemoryWrite,
  input  logic [1:0]  MemoryAccessWidth,
  input  logic        MemoryAccessSignExtend,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic        MemRequest,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [3:0]  MemByteEnable,
  output logic [31:0] MemWriteData,
  input  logic        MemReady,
  input  logic [31:0] MemReadData
);

  localparam int unsigned CntW = (WaitLimit > 1) ? $clog2(WaitLimit) : 1;

  lsu_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]    width_q, width_d;
  logic [1:0]    offset_q, offset_d;
  logic          sign_q, sign_d;
  logic          is_read_q, is_read_d;

  logic          busy_d, done_d, fault_d, req_d, we_d;
  logic [31:0]   load_d, addr_d, wdata_d;
  logic [3:0]    be_d;
  logic [31:0]   extended;
  logic          check_fail;

  load_extend u_load_extend (
    .read_word   (MemReadData),
    .offset      (offset_q),
    .width       (width_q),
    .sign_extend (sign_q),
    .load_data_c (extended)
  );

  assign check_fail = (IsMemoryRead == IsMemoryWrite) |
                      misaligned(MemoryAccessWidth, Address[1:0]);

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    offset_d  = offset_q;
    sign_d    = sign_q;
    is_read_d = is_read_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    req_d     = 1'b0;
    we_d      = MemWriteEnable;
    load_d    = LoadData;
    addr_d    = MemAddress;
    be_d      = MemByteEnable;
    wdata_d   = MemWriteData;
    case (state_q)
      IDLE: begin
        if (Start) begin
          width_d   = MemoryAccessWidth;
          offset_d  = Address[1:0];
          sign_d    = MemoryAccessSignExtend;
          is_read_d = IsMemoryRead;
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (check_fail) begin
            state_d = COMPLETE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = REQUEST;
            req_d   = 1'b1;
            we_d    = IsMemoryWrite;
            addr_d  = {Address[31:2], 2'b00};
            be_d    = byte_enable(MemoryAccessWidth, Address[1:0]);
            wdata_d = lane_data(MemoryAccessWidth, Address[1:0], StoreData);
          end
        end
      end
      REQUEST: begin
        busy_d = 1'b1;
        if (MemReady) begin
          state_d = COMPLETE;
          done_d  = 1'b1;
          we_d    = 1'b0;
          if (is_read_q) load_d = extended;
        end else if (cnt_q == CntW'(WaitLimit - 1)) begin
          state_d = COMPLETE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          we_d    = 1'b0;
        end else begin
          req_d = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      width_q        <= WIDTH_BYTE;
      offset_q       <= 2'b00;
      sign_q         <= 1'b0;
      is_read_q      <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Fault          <= 1'b0;
      LoadData       <= '0;
      MemRequest     <= 1'b0;
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemByteEnable  <= '0;
      MemWriteData   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      width_q        <= width_d;
      offset_q       <= offset_d;
      sign_q         <= sign_d;
      is_read_q      <= is_read_d;
      Busy           <= busy_d;
      Done           <= done_d;
      Fault          <= fault_d;
      LoadData       <= load_d;
      MemRequest     <= req_d;
      MemWriteEnable <= we_d;
      MemAddress     <= addr_d;
      MemByteEnable  <= be_d;
      MemWriteData   <= wdata_d;
    end
  end

endmodule
